// File: rtl/irq_sched_if.sv
// Core-side bundle for irq_sched: event/mask/boundary inputs and PC-mux control outputs.
// The core (or bench) drives through the master modport; the scheduler uses slave.
interface irq_sched_if #(
    parameter int NIRQ = 4,
    parameter int PCW  = 10
);
    logic [NIRQ-1:0] irq;
    logic            mask_we;
    logic [NIRQ-1:0] mask_d;
    logic            cpu_ready;
    logic [PCW-1:0]  pc_next;
    logic            reti;

    logic            int_take;
    logic [PCW-1:0]  vector;
    logic            ret_take;
    logic [PCW-1:0]  epc;
    logic            in_service;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] mask;

    modport master (
        output irq, mask_we, mask_d, cpu_ready, pc_next, reti,
        input  int_take, vector, ret_take, epc, in_service, pending, mask
    );

    modport slave (
        input  irq, mask_we, mask_d, cpu_ready, pc_next, reti,
        output int_take, vector, ret_take, epc, in_service, pending, mask
    );
endinterface

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge-latched sources, masked priority pick, PC redirect and return.
// Define IRQ_SCHED_RR_EN for round-robin priority instead of fixed lowest-index-wins.
module irq_sched #(
    parameter int                 NIRQ       = 4,
    parameter int                 PCW        = 10,
    parameter logic [PCW-1:0]     VEC_BASE   = 10'h3C0,
    parameter int                 VEC_STRIDE = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    irq_sched_if.slave  bus
);
    // state     | meaning
    // S_IDLE    | waiting for eligible event at an instruction boundary
    // S_TAKE    | one cycle: redirect PC to vector, save epc, clear pending bit
    // S_SERVICE | handler running, no nesting
    // S_RET     | one cycle: redirect PC to epc
    localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TAKE, S_SERVICE, S_RET} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NIRQ-1:0] r_prev;
    logic [NIRQ-1:0] r_pending;
    logic [NIRQ-1:0] r_mask;
    logic [IW-1:0]   r_idx;
    logic [PCW-1:0]  r_epc;

    logic [NIRQ-1:0] w_edge;
    logic [NIRQ-1:0] w_eligible;
    logic [NIRQ-1:0] w_clr;
    logic [IW-1:0]   w_sel_idx;
    logic            w_sel_vld;
    logic [PCW-1:0]  w_vec_calc;

    assign w_edge     = bus.irq & ~r_prev;
    assign w_eligible = r_pending & r_mask;
    assign w_vec_calc = VEC_BASE + PCW'(r_idx) * PCW'(VEC_STRIDE);

`ifdef IRQ_SCHED_RR_EN
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_cand;

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NIRQ; k++) begin
            w_cand = IW'((int'(r_last) + 1 + k) % NIRQ);
            if (!w_sel_vld && w_eligible[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_last <= '0;
        else if (r_state == S_TAKE)
            r_last <= r_idx;
    end
`else
    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IW'(k);
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_sel_vld && bus.cpu_ready) w_state_nxt = S_TAKE;
            S_TAKE:    w_state_nxt = S_SERVICE;
            S_SERVICE: if (bus.reti) w_state_nxt = S_RET;
            S_RET:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.int_take   = (r_state == S_TAKE);
        bus.ret_take   = (r_state == S_RET);
        bus.in_service = (r_state == S_SERVICE);
        bus.vector     = (r_state == S_TAKE) ? w_vec_calc : '0;
    end

    assign bus.epc     = r_epc;
    assign bus.pending = r_pending;
    assign bus.mask    = r_mask;

    // New edges are OR-ed in after the clear so a same-cycle re-event stays pending.
    assign w_clr = (r_state == S_TAKE) ? (NIRQ'(1) << r_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_idx     <= '0;
            r_epc     <= '0;
        end else begin
            r_prev    <= bus.irq;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (bus.mask_we)
                r_mask <= bus.mask_d;
            if (r_state == S_IDLE && w_state_nxt == S_TAKE)
                r_idx <= w_sel_idx;
            if (r_state == S_TAKE)
                r_epc <= bus.pc_next;
        end
    end
endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: scoreboard of expected vector/epc per take.
module tb_irq_sched;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    irq_sched_if #(.NIRQ(4), .PCW(10)) bus ();

    irq_sched dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [9:0] vec;
        logic [9:0] epc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_checks = 0;
    int   m_pass   = 0;
    int   n_takes  = 0;
    logic       epc_due = 1'b0;
    logic [9:0] epc_exp;

    // Scoreboard monitor: pop one expectation per take, check epc one cycle later.
    always @(negedge clk) begin
        if (epc_due) begin
            m_checks++;
            if (bus.epc !== epc_exp)
                $display("FAIL sb_epc: got %h want %h", bus.epc, epc_exp);
            else
                m_pass++;
            epc_due = 1'b0;
        end
        if (bus.int_take === 1'b1) begin
            n_takes++;
            m_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_take: unexpected take, vector %h", bus.vector);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.vector !== mon_e.vec)
                    $display("FAIL sb_vector: got %h want %h", bus.vector, mon_e.vec);
                else
                    m_pass++;
                epc_exp = mon_e.epc;
                epc_due = 1'b1;
            end
        end
        if (bus.int_take === 1'b1 || bus.ret_take === 1'b1) begin
            m_checks++;
            if (bus.int_take === 1'b1 && bus.ret_take === 1'b1)
                $display("FAIL take_excl: int_take and ret_take both 1, want one");
            else
                m_pass++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [9:0] v, input logic [9:0] e);
        exp_t x;
        x.vec = v;
        x.epc = e;
        exp_q.push_back(x);
    endtask

    task automatic pulse(input logic [3:0] b);
        bus.irq = bus.irq | b;
        tick();
        bus.irq = bus.irq & ~b;
    endtask

    task automatic set_mask(input logic [3:0] m);
        bus.mask_we = 1'b1;
        bus.mask_d  = m;
        tick();
        bus.mask_we = 1'b0;
    endtask

    task automatic wait_take(input int max_c, input string nm);
        int i;
        i = 0;
        while (bus.int_take !== 1'b1 && i < max_c) begin
            tick();
            i++;
        end
        n_checks++;
        if (bus.int_take !== 1'b1)
            $display("FAIL %s: int_take still %b after %0d cycles, want 1", nm, bus.int_take, max_c);
        else
            n_pass++;
    endtask

    task automatic do_reti(input string nm);
        bus.reti = 1'b1;
        tick();
        n_checks++;
        if (bus.ret_take !== 1'b1 || bus.in_service !== 1'b0)
            $display("FAIL %s: ret_take=%b in_service=%b, want 1/0", nm, bus.ret_take, bus.in_service);
        else
            n_pass++;
        bus.reti = 1'b0;
        tick();
        n_checks++;
        if (bus.ret_take !== 1'b0 || bus.in_service !== 1'b0)
            $display("FAIL %s_after: ret_take=%b in_service=%b, want 0/0", nm, bus.ret_take, bus.in_service);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.int_take, bus.ret_take, bus.in_service} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {bus.int_take, bus.ret_take, bus.in_service});
        else
            n_pass++;
        n_checks++;
        if (bus.pending !== 4'b0 || bus.mask !== 4'b0)
            $display("FAIL rst_pend_mask: got %b/%b want 0000/0000", bus.pending, bus.mask);
        else
            n_pass++;
        n_checks++;
        if (bus.epc !== 10'h0 || bus.vector !== 10'h0)
            $display("FAIL rst_pc: epc %h vector %h want 000/000", bus.epc, bus.vector);
        else
            n_pass++;
    endtask

    task automatic test_basic_take();
        set_mask(4'b1111);
        bus.cpu_ready = 1'b1;
        bus.pc_next   = 10'h025;
        push_exp(10'h3E0, 10'h025);
        pulse(4'b0100);
        n_checks++;
        if (bus.pending !== 4'b0100)
            $display("FAIL basic_pend: got %b want 0100", bus.pending);
        else
            n_pass++;
        tick();
        n_checks++;
        if (bus.int_take !== 1'b1 || bus.vector !== 10'h3E0)
            $display("FAIL basic_latency: int_take %b vector %h want 1/3e0", bus.int_take, bus.vector);
        else
            n_pass++;
        tick();
        bus.pc_next = 10'h1AB;
        n_checks++;
        if (bus.in_service !== 1'b1 || bus.pending !== 4'b0 || bus.epc !== 10'h025)
            $display("FAIL basic_service: in_service %b pending %b epc %h want 1/0000/025",
                     bus.in_service, bus.pending, bus.epc);
        else
            n_pass++;
    endtask

    task automatic test_reti();
        tick();
        bus.pc_next = 10'h2F2;
        do_reti("reti");
        n_checks++;
        if (bus.epc !== 10'h025)
            $display("FAIL reti_epc: got %h want 025", bus.epc);
        else
            n_pass++;
    endtask

    task automatic test_priority();
        bus.pc_next = 10'h040;
`ifdef IRQ_SCHED_RR_EN
        push_exp(10'h3F0, 10'h040);
        push_exp(10'h3D0, 10'h050);
`else
        push_exp(10'h3D0, 10'h040);
        push_exp(10'h3F0, 10'h050);
`endif
        pulse(4'b1010);
        wait_take(5, "prio_first");
        tick();
        bus.pc_next = 10'h050;
        n_checks++;
`ifdef IRQ_SCHED_RR_EN
        if (bus.pending !== 4'b0010)
            $display("FAIL prio_left: got %b want 0010", bus.pending);
`else
        if (bus.pending !== 4'b1000)
            $display("FAIL prio_left: got %b want 1000", bus.pending);
`endif
        else
            n_pass++;
        do_reti("prio_reti1");
        wait_take(5, "prio_second");
        tick();
        do_reti("prio_reti2");
    endtask

    task automatic test_mask();
        int t0;
        set_mask(4'b0000);
        t0 = n_takes;
        bus.pc_next = 10'h077;
        pulse(4'b0001);
        repeat (5) tick();
        n_checks++;
        if (bus.pending !== 4'b0001 || n_takes != t0)
            $display("FAIL mask_hold: pending %b takes %0d want 0001/0", bus.pending, n_takes - t0);
        else
            n_pass++;
        push_exp(10'h3C0, 10'h077);
        bus.mask_we = 1'b1;
        bus.mask_d  = 4'b0001;
        tick();
        bus.mask_we = 1'b0;
        n_checks++;
        if (bus.mask !== 4'b0001 || bus.int_take !== 1'b0)
            $display("FAIL mask_load: mask %b int_take %b want 0001/0", bus.mask, bus.int_take);
        else
            n_pass++;
        tick();
        n_checks++;
        if (bus.int_take !== 1'b1)
            $display("FAIL mask_take: int_take %b want 1", bus.int_take);
        else
            n_pass++;
        tick();
        do_reti("mask_reti");
        set_mask(4'b1111);
    endtask

    task automatic test_held();
        int t0;
        t0 = n_takes;
        bus.pc_next = 10'h100;
        push_exp(10'h3C0, 10'h100);
        bus.irq[0] = 1'b1;
        repeat (20) tick();
        bus.irq[0] = 1'b0;
        n_checks++;
        if (n_takes - t0 != 1 || bus.in_service !== 1'b1)
            $display("FAIL held_once: takes %0d in_service %b want 1/1", n_takes - t0, bus.in_service);
        else
            n_pass++;
        tick();
        push_exp(10'h3C0, 10'h100);
        pulse(4'b0001);
        n_checks++;
        if (bus.pending !== 4'b0001)
            $display("FAIL held_repend: got %b want 0001", bus.pending);
        else
            n_pass++;
        do_reti("held_reti1");
        wait_take(5, "held_retake");
        tick();
        do_reti("held_reti2");
        n_checks++;
        if (n_takes - t0 != 2)
            $display("FAIL held_total: takes %0d want 2", n_takes - t0);
        else
            n_pass++;
    endtask

    task automatic test_set_wins();
        bus.pc_next = 10'h123;
        push_exp(10'h3D0, 10'h123);
        push_exp(10'h3D0, 10'h123);
        pulse(4'b0010);
        tick();
        n_checks++;
        if (bus.int_take !== 1'b1)
            $display("FAIL setwins_take: int_take %b want 1", bus.int_take);
        else
            n_pass++;
        bus.irq[1] = 1'b1;
        tick();
        bus.irq[1] = 1'b0;
        n_checks++;
        if (bus.pending !== 4'b0010)
            $display("FAIL setwins_pend: got %b want 0010", bus.pending);
        else
            n_pass++;
        do_reti("setwins_reti1");
        wait_take(5, "setwins_retake");
        tick();
        do_reti("setwins_reti2");
    endtask

    task automatic test_cpu_not_ready();
        int t0;
        t0 = n_takes;
        bus.cpu_ready = 1'b0;
        bus.pc_next   = 10'h0AA;
        push_exp(10'h3F0, 10'h0AA);
        pulse(4'b1000);
        repeat (10) tick();
        n_checks++;
        if (bus.pending !== 4'b1000 || n_takes != t0)
            $display("FAIL notready_wait: pending %b takes %0d want 1000/0", bus.pending, n_takes - t0);
        else
            n_pass++;
        bus.cpu_ready = 1'b1;
        wait_take(5, "notready_take");
        tick();
        do_reti("notready_reti");
    endtask

    task automatic test_reset_mid();
        bus.pc_next = 10'h155;
        push_exp(10'h3C0, 10'h155);
        pulse(4'b0001);
        wait_take(5, "rstmid_take");
        tick();
        pulse(4'b0100);
        n_checks++;
        if (bus.pending !== 4'b0100 || bus.in_service !== 1'b1)
            $display("FAIL rstmid_pre: pending %b in_service %b want 0100/1", bus.pending, bus.in_service);
        else
            n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({bus.int_take, bus.ret_take, bus.in_service} !== 3'b000 || bus.pending !== 4'b0 ||
            bus.mask !== 4'b0 || bus.epc !== 10'h0 || bus.vector !== 10'h0)
            $display("FAIL rstmid_outs: flags %b pending %b mask %b epc %h vector %h want all 0",
                     {bus.int_take, bus.ret_take, bus.in_service}, bus.pending, bus.mask, bus.epc, bus.vector);
        else
            n_pass++;
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        n_checks++;
        if (bus.ret_take !== 1'b0 || bus.in_service !== 1'b0)
            $display("FAIL rstmid_reti: ret_take %b in_service %b want 0/0", bus.ret_take, bus.in_service);
        else
            n_pass++;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.irq       = '0;
        bus.mask_we   = 1'b0;
        bus.mask_d    = '0;
        bus.cpu_ready = 1'b0;
        bus.pc_next   = '0;
        bus.reti      = 1'b0;
        test_reset();
        test_basic_take();
        test_reti();
        test_priority();
        test_mask();
        test_held();
        test_set_wins();
        test_cpu_not_ready();
        test_reset_mid();
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL sb_drain: %0d expected takes never seen, want 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass + m_pass, n_checks + m_checks);
        $finish;
    end
endmodule
